// File: rtl/addsub_serial_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor tile.
// Bit positions on ui_in/uio_in/uo_out live here so every file agrees on the pinout.
package addsub_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DIGIT_W = 4;

   // uio_in control bits
   localparam int UI_START = 0;
   localparam int UI_SUB   = 1;
   localparam int UI_VALID = 2;

   // uo_out fields
   localparam int UO_SUM_LSB = 0;
   localparam int UO_CARRY   = 4;
   localparam int UO_OVF     = 5;
   localparam int UO_DVALID  = 6;
   localparam int UO_DONE    = 7;

   function automatic int cnt_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// TinyTapeout pin bundle for the serial adder tile.
// master drives the operand and control pins, slave is the tile side.
interface addsub_serial_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/addsub_digit.sv
// One 4-bit digit of the adder/subtractor: four chained full adders with B
// conditionally inverted, plus signed-overflow detection on the top bit.
module addsub_digit
   import addsub_serial_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   input  logic               sub,
   output logic [DIGIT_W-1:0] s,
   output logic               cout,
   output logic               ovf
);

   logic [DIGIT_W-1:0] w_bx;
   logic [DIGIT_W:0]   w_c;

   assign w_bx   = b ^ {DIGIT_W{sub}};
   assign w_c[0] = cin;

   for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
      assign s[i]     = a[i] ^ w_bx[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
   end

   assign cout = w_c[DIGIT_W];
   // Only meaningful on the most significant digit; the top level latches it there.
   assign ovf  = (a[DIGIT_W-1] == w_bx[DIGIT_W-1]) && (s[DIGIT_W-1] != a[DIGIT_W-1]);

endmodule

// File: rtl/tt_um_kbieganski_addsub_serial.sv
// Digit-serial WIDTH-bit adder/subtractor: one digit pair per accepted cycle,
// LSB first, carry held in a register between digits.
module tt_um_kbieganski_addsub_serial
   import addsub_serial_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int DIGITS = WIDTH / DIGIT_W;
   localparam int CNT_W  = cnt_width(DIGITS);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_sub;
   logic [DIGIT_W-1:0] r_sum;
   logic               r_cout;
   logic               r_ovf;
   logic               r_dvalid;
   logic               r_done;

   state_t             w_nxt_state;
   logic [CNT_W-1:0]   w_nxt_cnt;
   logic               w_nxt_carry;
   logic               w_nxt_sub;
   logic [DIGIT_W-1:0] w_nxt_sum;
   logic               w_nxt_cout;
   logic               w_nxt_ovf;
   logic               w_nxt_dvalid;
   logic               w_nxt_done;

   logic               w_start;
   logic               w_valid;
   logic               w_last;
   logic [DIGIT_W-1:0] w_s;
   logic               w_c;
   logic               w_o;
   logic               w_unused;

   assign w_start  = uio_in[UI_START];
   assign w_valid  = uio_in[UI_VALID];
   assign w_last   = (r_cnt == CNT_W'(DIGITS - 1));
   assign w_unused = &{1'b0, uio_in[7:3]};

   addsub_digit u_digit (
      .a    (ui_in[DIGIT_W-1:0]),
      .b    (ui_in[2*DIGIT_W-1:DIGIT_W]),
      .cin  (r_carry),
      .sub  (r_sub),
      .s    (w_s),
      .cout (w_c),
      .ovf  (w_o)
   );

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_cnt    = r_cnt;
      w_nxt_carry  = r_carry;
      w_nxt_sub    = r_sub;
      w_nxt_sum    = r_sum;
      w_nxt_cout   = r_cout;
      w_nxt_ovf    = r_ovf;
      w_nxt_dvalid = r_dvalid;
      w_nxt_done   = r_done;

      // start wins in every state; a subtract seeds the carry with the +1 of two's complement
      if (w_start) begin
         w_nxt_state  = ST_RUN;
         w_nxt_sub    = uio_in[UI_SUB];
         w_nxt_carry  = uio_in[UI_SUB];
         w_nxt_cnt    = '0;
         w_nxt_cout   = 1'b0;
         w_nxt_ovf    = 1'b0;
         w_nxt_dvalid = 1'b0;
         w_nxt_done   = 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_valid) begin
                  w_nxt_sum    = w_s;
                  w_nxt_dvalid = 1'b1;
                  w_nxt_carry  = w_c;
                  w_nxt_cnt    = r_cnt + CNT_W'(1);
                  if (w_last) begin
                     w_nxt_cout  = w_c;
                     w_nxt_ovf   = w_o;
                     w_nxt_done  = 1'b1;
                     w_nxt_state = ST_DONE;
                  end
               end else begin
                  w_nxt_dvalid = 1'b0;
               end
            end
            ST_DONE: w_nxt_dvalid = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_sub    <= 1'b0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_dvalid <= 1'b0;
         r_done   <= 1'b0;
      end else if (ena) begin
         r_state  <= w_nxt_state;
         r_cnt    <= w_nxt_cnt;
         r_carry  <= w_nxt_carry;
         r_sub    <= w_nxt_sub;
         r_sum    <= w_nxt_sum;
         r_cout   <= w_nxt_cout;
         r_ovf    <= w_nxt_ovf;
         r_dvalid <= w_nxt_dvalid;
         r_done   <= w_nxt_done;
      end
   end

   assign uo_out[UO_SUM_LSB +: DIGIT_W] = r_sum;
   assign uo_out[UO_CARRY]              = r_cout;
   assign uo_out[UO_OVF]                = r_ovf;
   assign uo_out[UO_DVALID]             = r_dvalid;
   assign uo_out[UO_DONE]               = r_done;
   assign uio_out                       = 8'h00;
   assign uio_oe                        = 8'h00;

endmodule

// File: tb/tb_tt_um_kbieganski_addsub_serial.sv
// Self-checking bench for the serial adder/subtractor: expected uo_out words are
// queued when a digit is driven and compared whenever digit_valid appears.
module tb_tt_um_kbieganski_addsub_serial;

   logic clk;
   logic rst_n;
   logic ena;

   addsub_serial_if bus ();

   tt_um_kbieganski_addsub_serial #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (bus.ui_in),
      .uio_in  (bus.uio_in),
      .uo_out  (bus.uo_out),
      .uio_out (bus.uio_out),
      .uio_oe  (bus.uio_oe)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_exp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // one cycle of stimulus, applied just after the falling edge
   task automatic step(input logic en, input logic rn, input logic st, input logic sb,
                       input logic v, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      ena         = en;
      rst_n       = rn;
      bus.ui_in   = {b, a};
      bus.uio_in  = {5'b0, v, sb, st};
   endtask

   task automatic idle();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   // Whole-word reference: adds in 17 bits, overflow from operand/result signs.
   task automatic push_expected(input logic [15:0] a, input logic [15:0] b, input logic sb, input int d);
      logic [15:0] bb;
      logic [16:0] r;
      logic        ov;
      logic [3:0]  dg;
      bb = sb ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {16'b0, sb};
      ov = (a[15] == bb[15]) && (r[15] != a[15]);
      dg = r[4*d +: 4];
      if (d == 3) last_exp = {1'b1, 1'b1, ov, r[16], dg};
      else        last_exp = {4'b0100, dg};
      exp_q.push_back(last_exp);
   endtask

   // gap_at: insert 3 in_valid-low cycles before that digit
   // frz_at: hold ena low 5 cycles before that digit
   // abort_at: stop before that digit without finishing
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sb,
                         input int gap_at, input int frz_at, input int abort_at);
      step(1'b1, 1'b1, 1'b1, sb, 1'b0, 4'h0, 4'h0);
      for (int d = 0; d < 4; d++) begin
         if (d == abort_at) return;
         if (d == gap_at)
            for (int g = 0; g < 3; g++) idle();
         if (d == frz_at) begin
            for (int k = 0; k < 5; k++) begin
               step(1'b0, 1'b1, 1'b1, ~sb, 1'b1, 4'hF, 4'hF);
               if (k > 0) chk("freeze_uo", {24'b0, bus.uo_out}, {24'b0, last_exp});
            end
         end
         step(1'b1, 1'b1, 1'b0, sb, 1'b1, a[4*d +: 4], b[4*d +: 4]);
         push_expected(a, b, sb, d);
      end
      idle();
      idle();
      chk("done_hold", {24'b0, bus.uo_out}, {24'b0, last_exp & 8'hBF});
   endtask

   // scoreboard: pop an expectation each time digit_valid shows after an enabled edge
   initial begin
      logic e;
      forever begin
         @(posedge clk);
         e = ena;
         @(negedge clk);
         if (e && bus.uo_out[6] === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_dv", {31'b0, bus.uo_out[6]}, 32'd0);
            else chk("digit", {24'b0, bus.uo_out}, {24'b0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      ena        = 1'b1;
      rst_n      = 1'b0;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      idle();
      chk("rst_uo", {24'b0, bus.uo_out}, 32'h00);
      chk("rst_uio_out", {24'b0, bus.uio_out}, 32'h00);
      chk("rst_uio_oe", {24'b0, bus.uio_oe}, 32'h00);

      // IDLE ignores in_valid
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 4'h4);
      idle();
      chk("idle_ignore", {24'b0, bus.uo_out}, 32'h00);

      run_op(16'h1234, 16'h4321, 1'b0, -1, -1, -1);
      run_op(16'hFFFF, 16'h0001, 1'b0, -1, -1, -1);
      run_op(16'h0005, 16'h0007, 1'b1, -1, -1, -1);
      run_op(16'h0007, 16'h0005, 1'b1, -1, -1, -1);
      run_op(16'h7FFF, 16'h0001, 1'b0, -1, -1, -1);
      run_op(16'h8000, 16'h0001, 1'b1, -1, -1, -1);

      // stall between digits 2 and 3, then an enable freeze mid-run
      run_op(16'h1234, 16'h4321, 1'b0, 2, -1, -1);
      run_op(16'h1234, 16'h4321, 1'b0, -1, 2, -1);

      // abort after two digits, restart with a full operation
      run_op(16'h1234, 16'h4321, 1'b0, -1, -1, 2);
      run_op(16'h0001, 16'h0001, 1'b0, -1, -1, -1);

      // reset mid-run: two digits in, then rst_n low while a digit is offered
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 4'h1);
      push_expected(16'h1234, 16'h4321, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 4'h2);
      push_expected(16'h1234, 16'h4321, 1'b0, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h3);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 4'h4);
      chk("rst_mid_uo", {24'b0, bus.uo_out}, 32'h00);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 4'h9);
         chk("post_rst_ignore", {24'b0, bus.uo_out}, 32'h00);
      end

      // random operands, both directions
      for (int n = 0; n < 6; n++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         logic        rs;
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         rs = 1'($urandom_range(0, 1));
         run_op(ra, rb, rs, -1, -1, -1);
      end

      idle();
      idle();
      chk("q_drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
